// File: rtl/bomb_scheduler.sv
// Bomb-drop arbiter and fuse sequencer: latches player drop requests, validates and
// commits them through one map write port, and issues the per-tick fuse step strobe.
module bomb_scheduler #(
    parameter int MAX_BOMBS = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic [1:0]   game_state,
    input  logic         reqA,
    input  logic         reqB,
    input  logic [3:0]   playerAx,
    input  logic [3:0]   playerAy,
    input  logic [3:0]   playerBx,
    input  logic [3:0]   playerBy,
    input  logic [199:0] cur_map,
    output logic         wr_en,
    output logic [3:0]   wr_x,
    output logic [3:0]   wr_y,
    output logic [1:0]   wr_val,
    output logic         step,
    output logic         grantA,
    output logic         grantB,
    output logic         denyA,
    output logic         denyB,
    output logic [2:0]   countA,
    output logic [2:0]   countB,
    output logic         busy
);

    typedef enum logic [2:0] {IDLE, ARB, WRITE, DENY, STEP, SETTLE} state_t;

    state_t state_q, state_d;

    logic       pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic       tick_pend_q, tick_pend_d;
    logic       rr_q, rr_d;
    logic [3:0] snap_ax_q, snap_ax_d, snap_ay_q, snap_ay_d;
    logic [3:0] snap_bx_q, snap_bx_d, snap_by_q, snap_by_d;
    logic [99:0] own_v_q, own_v_d;
    logic [99:0] own_b_q, own_b_d;

    logic       wr_en_q, wr_en_d;
    logic [3:0] wr_x_q, wr_x_d, wr_y_q, wr_y_d;
    logic [1:0] wr_val_q, wr_val_d;
    logic       step_q, step_d;
    logic       grant_a_q, grant_a_d, grant_b_q, grant_b_d;
    logic       deny_a_q, deny_a_d, deny_b_q, deny_b_d;
    logic [2:0] count_a_q, count_a_d, count_b_q, count_b_d;
    logic       busy_q, busy_d;

    // Cells that are exploding right now and still belong to a player.
    logic [99:0] boom;
    genvar gi;
    generate
        for (gi = 0; gi < 100; gi++) begin : g_boom
            assign boom[gi] = (cur_map[2*gi +: 2] == 2'd3) && own_v_q[gi];
        end
    endgenerate

    logic       win_b;
    logic [3:0] win_x, win_y;
    logic [2:0] win_cnt;
    logic       in_bounds;
    logic [6:0] win_idx;
    logic       accept;
    logic [6:0] boom_a, boom_b;

    always_comb begin
        win_b     = (pend_a_q && pend_b_q) ? rr_q : pend_b_q;
        win_x     = win_b ? snap_bx_q : snap_ax_q;
        win_y     = win_b ? snap_by_q : snap_ay_q;
        win_cnt   = win_b ? count_b_q : count_a_q;
        in_bounds = (win_x >= 4'd1) && (win_x <= 4'd8) && (win_y >= 4'd1) && (win_y <= 4'd8);
        // Out-of-bounds snapshots are clamped to cell 0 so the map select stays in range.
        win_idx   = in_bounds ? 7'(10 * win_x + win_y) : 7'd0;
        accept    = (game_state == 2'd0) && in_bounds
                    && (cur_map[{win_idx, 1'b0} +: 2] == 2'd0)
                    && !own_v_q[win_idx]
                    && (win_cnt < 3'(MAX_BOMBS));

        boom_a = 7'd0;
        boom_b = 7'd0;
        for (int i = 0; i < 100; i++) begin
            if (boom[i]) begin
                if (own_b_q[i]) boom_b = boom_b + 7'd1;
                else            boom_a = boom_a + 7'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_a_d    = pend_a_q;
        pend_b_d    = pend_b_q;
        tick_pend_d = tick_pend_q;
        rr_d        = rr_q;
        snap_ax_d   = snap_ax_q;
        snap_ay_d   = snap_ay_q;
        snap_bx_d   = snap_bx_q;
        snap_by_d   = snap_by_q;
        own_v_d     = own_v_q;
        own_b_d     = own_b_q;
        wr_en_d     = 1'b0;
        wr_x_d      = wr_x_q;
        wr_y_d      = wr_y_q;
        wr_val_d    = 2'd0;
        step_d      = 1'b0;
        grant_a_d   = 1'b0;
        grant_b_d   = 1'b0;
        deny_a_d    = 1'b0;
        deny_b_d    = 1'b0;
        count_a_d   = count_a_q;
        count_b_d   = count_b_q;

        case (state_q)
            IDLE: begin
                if (tick || tick_pend_q) begin
                    state_d = STEP;
                    step_d  = 1'b1;
                end else if (pend_a_q || pend_b_q) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (pend_a_q && pend_b_q) rr_d = ~rr_q;
                if (win_b) pend_b_d = 1'b0;
                else       pend_a_d = 1'b0;
                if (accept) begin
                    state_d          = WRITE;
                    wr_en_d          = 1'b1;
                    wr_x_d           = win_x;
                    wr_y_d           = win_y;
                    wr_val_d         = 2'd1;
                    grant_a_d        = !win_b;
                    grant_b_d        = win_b;
                    own_v_d[win_idx] = 1'b1;
                    own_b_d[win_idx] = win_b;
                    if (win_b) count_b_d = count_b_q + 3'd1;
                    else       count_a_d = count_a_q + 3'd1;
                end else begin
                    state_d  = DENY;
                    deny_a_d = !win_b;
                    deny_b_d = win_b;
                end
            end
            WRITE, DENY, SETTLE: state_d = IDLE;
            STEP: begin
                state_d     = SETTLE;
                tick_pend_d = 1'b0;
                own_v_d     = own_v_q & ~boom;
                count_a_d   = (boom_a >= {4'd0, count_a_q}) ? 3'd0 : count_a_q - boom_a[2:0];
                count_b_d   = (boom_b >= {4'd0, count_b_q}) ? 3'd0 : count_b_q - boom_b[2:0];
            end
            default: state_d = IDLE;
        endcase

        // A tick seen while busy is remembered; one landing in STEP counts as a new tick.
        if (tick && state_q != IDLE) tick_pend_d = 1'b1;
        if (reqA && !pend_a_q) begin
            pend_a_d  = 1'b1;
            snap_ax_d = playerAx;
            snap_ay_d = playerAy;
        end
        if (reqB && !pend_b_q) begin
            pend_b_d  = 1'b1;
            snap_bx_d = playerBx;
            snap_by_d = playerBy;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_a_q    <= 1'b0;
            pend_b_q    <= 1'b0;
            tick_pend_q <= 1'b0;
            rr_q        <= 1'b0;
            snap_ax_q   <= 4'd0;
            snap_ay_q   <= 4'd0;
            snap_bx_q   <= 4'd0;
            snap_by_q   <= 4'd0;
            own_v_q     <= '0;
            own_b_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_x_q      <= 4'd0;
            wr_y_q      <= 4'd0;
            wr_val_q    <= 2'd0;
            step_q      <= 1'b0;
            grant_a_q   <= 1'b0;
            grant_b_q   <= 1'b0;
            deny_a_q    <= 1'b0;
            deny_b_q    <= 1'b0;
            count_a_q   <= 3'd0;
            count_b_q   <= 3'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_a_q    <= pend_a_d;
            pend_b_q    <= pend_b_d;
            tick_pend_q <= tick_pend_d;
            rr_q        <= rr_d;
            snap_ax_q   <= snap_ax_d;
            snap_ay_q   <= snap_ay_d;
            snap_bx_q   <= snap_bx_d;
            snap_by_q   <= snap_by_d;
            own_v_q     <= own_v_d;
            own_b_q     <= own_b_d;
            wr_en_q     <= wr_en_d;
            wr_x_q      <= wr_x_d;
            wr_y_q      <= wr_y_d;
            wr_val_q    <= wr_val_d;
            step_q      <= step_d;
            grant_a_q   <= grant_a_d;
            grant_b_q   <= grant_b_d;
            deny_a_q    <= deny_a_d;
            deny_b_q    <= deny_b_d;
            count_a_q   <= count_a_d;
            count_b_q   <= count_b_d;
            busy_q      <= busy_d;
        end
    end

    assign wr_en  = wr_en_q;
    assign wr_x   = wr_x_q;
    assign wr_y   = wr_y_q;
    assign wr_val = wr_val_q;
    assign step   = step_q;
    assign grantA = grant_a_q;
    assign grantB = grant_b_q;
    assign denyA  = deny_a_q;
    assign denyB  = deny_b_q;
    assign countA = count_a_q;
    assign countB = count_b_q;
    assign busy   = busy_q;

endmodule
